stair_seq_gen: RTL and testbench

- Parametrised "staircase" sequence generator, successor to the fixed 0..9 generator.
- Emits each value v for exactly v enabled cycles, sweeping MIN_VAL..MAX_VAL.
- Two sweep modes: ascending-wrap and up/down triangle.
- Adds enable gating, an output-valid flag and a sweep-wrap pulse; used as a pattern source for datapath and counter tests.

---
 rtl/stair_seq_gen.sv | 207 ++++++++++++++++++++
 tb/tb_stair_seq_gen.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/stair_seq_gen.sv
// -----------------------------------------------------------------------------
// stair_seq_gen -- parametrised staircase sequence generator.
//
// Each value v is presented on out_o for exactly v enabled cycles. A sweep
// either ascends MIN..MAX and wraps (mode 0) or climbs MIN..MAX and then
// descends MAX-1..MIN+1 (mode 1, triangle). The mode is latched at every
// sweep start, so a change made mid-sweep applies from the next sweep.
//
// Optional build macro: STAIR_SEQ_PROG_BOUNDS_EN
//   When defined, cfg_min_i/cfg_max_i are sampled at every sweep start and
//   replace MIN_VAL/MAX_VAL for that sweep. An illegal pair (min 0 or
//   min > max) falls back to the parameter bounds.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset
//   en_i         advance enable; low freezes all state and outputs
//   mode_i       0 = ascending wrap, 1 = triangle
//   cfg_min_i    (macro only) programmable low bound
//   cfg_max_i    (macro only) programmable high bound
//   out_o        current sequence value (registered)
//   out_valid_o  high once the first value has been loaded
//   wrap_o       high during the final enabled cycle of a sweep
// -----------------------------------------------------------------------------
module stair_seq_gen #(
  parameter int WIDTH   = 4,
  parameter int MIN_VAL = 1,
  parameter int MAX_VAL = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             mode_i,
`ifdef STAIR_SEQ_PROG_BOUNDS_EN
  input  logic [WIDTH-1:0] cfg_min_i,
  input  logic [WIDTH-1:0] cfg_max_i,
`endif
  output logic [WIDTH-1:0] out_o,
  output logic             out_valid_o,
  output logic             wrap_o
);

  // Reject parameter sets that would need a zero-length hold or an inverted
  // or unrepresentable range.
  if ((MIN_VAL < 1) || (MIN_VAL > MAX_VAL) || (MAX_VAL > ((2 ** WIDTH) - 1))) begin : g_param_check
    $error("stair_seq_gen: illegal MIN_VAL/MAX_VAL for this WIDTH");
  end

  localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

  typedef enum logic [1:0] {
    S_PRIME = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             dir_q, dir_d;     // 0 = climbing, 1 = descending
  logic             mode_q, mode_d;   // mode latched for the current sweep
  logic             reload_s;         // this edge starts a new sweep

  logic [WIDTH-1:0] lo_s, hi_s;         // bounds of the current sweep
  logic [WIDTH-1:0] new_lo_s, new_hi_s; // bounds a sweep starting now would use
  logic [WIDTH-1:0] lo_nxt_s, hi_nxt_s; // bounds in force after this edge

  // True when value v, once its hold completes, is the last value of the sweep.
  // In the descending leg v >= lo+1, so v-1 cannot underflow; hi >= lo always.
  function automatic logic sweep_end(
    input logic [WIDTH-1:0] v,
    input logic             dir_down,
    input logic             tri_mode,
    input logic [WIDTH-1:0] lo,
    input logic [WIDTH-1:0] hi
  );
    logic r;
    if (!tri_mode) begin
      r = (v == hi);
    end else if (!dir_down) begin
      // A triangle only ends while climbing when there is no room to descend.
      r = (v == hi) && ((hi - lo) <= ONE_W);
    end else begin
      r = ((v - ONE_W) == lo);
    end
    return r;
  endfunction

`ifdef STAIR_SEQ_PROG_BOUNDS_EN
  logic [WIDTH-1:0] lo_q, hi_q;
  logic             cfg_bad_s;

  assign cfg_bad_s = (cfg_min_i == {WIDTH{1'b0}}) || (cfg_min_i > cfg_max_i);
  assign new_lo_s  = cfg_bad_s ? MIN_W : cfg_min_i;
  assign new_hi_s  = cfg_bad_s ? MAX_W : cfg_max_i;
  assign lo_s      = lo_q;
  assign hi_s      = hi_q;
  assign lo_nxt_s  = reload_s ? new_lo_s : lo_q;
  assign hi_nxt_s  = reload_s ? new_hi_s : hi_q;
`else
  assign new_lo_s  = MIN_W;
  assign new_hi_s  = MAX_W;
  assign lo_s      = MIN_W;
  assign hi_s      = MAX_W;
  assign lo_nxt_s  = MIN_W;
  assign hi_nxt_s  = MAX_W;
`endif

  // Next-state computation for one enabled edge.
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    dir_d    = dir_q;
    mode_d   = mode_q;
    reload_s = 1'b0;

    case (state_q)
      S_PRIME: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        reload_s = 1'b1;
        state_d  = S_RUN;
      end
      S_RUN: begin
        if (cnt_q != out_q) begin
          cnt_d = cnt_q + ONE_W;
        end else if (sweep_end(out_q, dir_q, mode_q, lo_s, hi_s)) begin
          reload_s = 1'b1;
        end else if (!mode_q) begin
          out_d = out_q + ONE_W;
          cnt_d = ONE_W;
        end else if (!dir_q) begin
          // Peak is shown once, then the descent starts at hi-1.
          if (out_q == hi_s) begin
            out_d = out_q - ONE_W;
            dir_d = 1'b1;
          end else begin
            out_d = out_q + ONE_W;
          end
          cnt_d = ONE_W;
        end else begin
          out_d = out_q - ONE_W;
          cnt_d = ONE_W;
        end
      end
      default: begin
        state_d = S_PRIME;
      end
    endcase

    // Sweep start: load the low bound and re-sample the mode.
    if (reload_s) begin
      out_d   = new_lo_s;
      cnt_d   = ONE_W;
      dir_d   = 1'b0;
      mode_d  = mode_i;
      valid_d = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  // wrap is evaluated on the post-edge state so it lines up with out_o.
  assign wrap_d = (state_d == S_RUN) && (cnt_d == out_d) &&
                  sweep_end(out_d, dir_d, mode_d, lo_nxt_s, hi_nxt_s);

  // State and output registers; en_i low freezes everything, wrap included.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_PRIME;
      out_q   <= {WIDTH{1'b0}};
      cnt_q   <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      dir_q   <= 1'b0;
      mode_q  <= 1'b0;
`ifdef STAIR_SEQ_PROG_BOUNDS_EN
      lo_q    <= MIN_W;
      hi_q    <= MAX_W;
`endif
    end else if (en_i) begin
      state_q <= state_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
`ifdef STAIR_SEQ_PROG_BOUNDS_EN
      lo_q    <= lo_nxt_s;
      hi_q    <= hi_nxt_s;
`endif
    end
  end

  assign out_o       = out_q;
  assign out_valid_o = valid_q;
  assign wrap_o      = wrap_q;

endmodule

// File: tb/tb_stair_seq_gen.sv
module tb_stair_seq_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       mode;
  logic [3:0] out;
  logic       out_valid;
  logic       wrap;
  logic [3:0] deg_out;
  logic       deg_valid;
  logic       deg_wrap;
  logic [3:0] pr_out;
  logic       pr_valid;
  logic       pr_wrap;
`ifdef STAIR_SEQ_PROG_BOUNDS_EN
  logic [3:0] cfg_min = 4'd2;
  logic [3:0] cfg_max = 4'd4;
`endif

  int checks = 0;
  int errors = 0;

  // Expected tables for the MIN=MAX=3 and MIN=2/MAX=3 triangle instances.
  int deg_out_tab [8] = '{0, 3, 3, 3, 3, 3, 3, 3};
  int deg_wrp_tab [8] = '{0, 0, 0, 1, 0, 0, 1, 0};
  int pr_out_tab  [8] = '{0, 2, 2, 3, 3, 3, 2, 2};
  int pr_wrp_tab  [8] = '{0, 0, 0, 0, 0, 1, 0, 0};

  always #5 clk = ~clk;

  stair_seq_gen #(.WIDTH(4), .MIN_VAL(1), .MAX_VAL(9)) u_dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode),
`ifdef STAIR_SEQ_PROG_BOUNDS_EN
    .cfg_min_i(cfg_min), .cfg_max_i(cfg_max),
`endif
    .out_o(out), .out_valid_o(out_valid), .wrap_o(wrap)
  );

  stair_seq_gen #(.WIDTH(4), .MIN_VAL(3), .MAX_VAL(3)) u_deg (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode),
`ifdef STAIR_SEQ_PROG_BOUNDS_EN
    .cfg_min_i(cfg_min), .cfg_max_i(cfg_max),
`endif
    .out_o(deg_out), .out_valid_o(deg_valid), .wrap_o(deg_wrap)
  );

  stair_seq_gen #(.WIDTH(4), .MIN_VAL(2), .MAX_VAL(3)) u_pair (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mode_i(mode),
`ifdef STAIR_SEQ_PROG_BOUNDS_EN
    .cfg_min_i(cfg_min), .cfg_max_i(cfg_max),
`endif
    .out_o(pr_out), .out_valid_o(pr_valid), .wrap_o(pr_wrap)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n enabled cycles of value v; wrap expected only on the last one if wl.
  task automatic run(input int v, input int n, input bit wl);
    for (int k = 1; k <= n; k++) begin
      tick();
      chk($sformatf("out v%0d k%0d", v, k), 32'(out), 32'(v));
      chk($sformatf("wrap v%0d k%0d", v, k), 32'(wrap), 32'(wl && (k == n)));
    end
  endtask

  initial begin
    rst  = 1'b0;
    en   = 1'b0;
    mode = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("reset out", 32'(out), 32'd0);
    chk("reset valid", 32'(out_valid), 32'd0);
    chk("reset wrap", 32'(wrap), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    en  = 1'b1;

    // PRIME cycle, then ascending sweep 1, 2x2 ... 9x9.
    tick();
    chk("prime out", 32'(out), 32'd0);
    chk("prime valid", 32'(out_valid), 32'd0);
    run(1, 1, 1'b0);
    chk("load valid", 32'(out_valid), 32'd1);
    for (int v = 2; v <= 9; v++) run(v, v, v == 9);

    // en low while wrap is high: everything holds.
    en = 1'b0;
    tick();
    chk("hold out", 32'(out), 32'd9);
    chk("hold wrap", 32'(wrap), 32'd1);
    tick();
    chk("hold wrap2", 32'(wrap), 32'd1);
    en = 1'b1;
    run(1, 1, 1'b0);
    run(2, 2, 1'b0);
    run(3, 1, 1'b0);

    // 1-on/1-off enable during the value-3 hold.
    for (int i = 0; i < 5; i++) begin
      en = (i % 2 == 1);
      tick();
      chk($sformatf("gate out %0d", i), 32'(out), 32'd3);
      chk($sformatf("gate wrap %0d", i), 32'(wrap), 32'd0);
    end
    en = 1'b1;
    run(4, 4, 1'b0);
    run(5, 1, 1'b0);

    // Switch to triangle mid-sweep: this sweep stays ascending.
    mode = 1'b1;
    run(5, 4, 1'b0);
    for (int v = 6; v <= 9; v++) run(v, v, v == 9);

    // Triangle sweep; mode goes back to 0 mid-sweep.
    run(1, 1, 1'b0);
    mode = 1'b0;
    for (int v = 2; v <= 9; v++) run(v, v, 1'b0);
    for (int v = 8; v >= 2; v--) run(v, v, v == 2);

    // Ascending again, then an asynchronous reset while out=7.
    run(1, 1, 1'b0);
    for (int v = 2; v <= 6; v++) run(v, v, 1'b0);
    run(7, 2, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async rst out", 32'(out), 32'd0);
    chk("async rst valid", 32'(out_valid), 32'd0);
    chk("async rst wrap", 32'(wrap), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("restart prime", 32'(out), 32'd0);
    chk("restart valid", 32'(out_valid), 32'd0);
    run(1, 1, 1'b0);
    run(2, 2, 1'b0);
    run(3, 1, 1'b0);

    // Degenerate and two-value triangle instances.
    rst  = 1'b1;
    mode = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("deg out %0d", i), 32'(deg_out), 32'(deg_out_tab[i]));
      chk($sformatf("deg wrap %0d", i), 32'(deg_wrap), 32'(deg_wrp_tab[i]));
      chk($sformatf("deg valid %0d", i), 32'(deg_valid), 32'(i != 0));
      chk($sformatf("pair out %0d", i), 32'(pr_out), 32'(pr_out_tab[i]));
      chk($sformatf("pair wrap %0d", i), 32'(pr_wrap), 32'(pr_wrp_tab[i]));
      chk($sformatf("pair valid %0d", i), 32'(pr_valid), 32'(i != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
